// File: rtl/bids22_ctrl_resp.sv
// bids22_ctrl_resp: command responder for the bid controller; owns lock key,
// mode FSM, configuration registers and round timer.
module bids22_ctrl_resp #(
   parameter int DATA_W        = 32,
   parameter int BAD_KEY_DELAY = 8,
   parameter int DEFAULT_TIMER = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] C_data,
   input  logic [3:0]        C_op,
   input  logic              C_start,
   output logic              ready,
   output logic [2:0]        err,
   output logic              roundOver,
   output logic              round_active,
   output logic [DATA_W-1:0] cfg_x_bal,
   output logic [DATA_W-1:0] cfg_y_bal,
   output logic [DATA_W-1:0] cfg_z_bal,
   output logic [2:0]        cfg_mask,
   output logic [DATA_W-1:0] cfg_cost,
   output logic [DATA_W-1:0] cfg_timer
);
   localparam int LW = $clog2(BAD_KEY_DELAY + 1);
   localparam logic [3:0] OP_NOP = 4'd0, OP_UNLOCK = 4'd1, OP_LOCK = 4'd2, OP_LOADX = 4'd3,
                          OP_LOADY = 4'd4, OP_LOADZ = 4'd5, OP_MASK = 4'd6, OP_TIMER = 4'd7,
                          OP_COST = 4'd8;
   localparam logic [2:0] E_OK = 3'b000, E_KEY = 3'b001, E_UNL = 3'b010, E_LCK = 3'b011,
                          E_CFG = 3'b100, E_INV = 3'b101, E_SUNL = 3'b110, E_STMR = 3'b111;

   typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKED, ST_ACTIVE, ST_OVER} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] key_q, key_d, rcnt_q, rcnt_d;
   logic [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d, cost_q, cost_d, timer_q, timer_d;
   logic [2:0]        mask_q, mask_d, err_q, err_d;
   logic [3:0]        op_prev_q, op_prev_d;
   logic [LW-1:0]     lcnt_q, lcnt_d;
   logic              ready_q, ready_d, over_q, over_d, active_q, active_d;
   logic              start_prev_q, start_prev_d;
   logic              cmd_go, start_edge, is_cfg, is_inv;

   assign cmd_go     = (C_op != op_prev_q) && (C_op != OP_NOP) && ready_q;
   assign start_edge = C_start && !start_prev_q;
   assign is_cfg     = (C_op >= OP_LOADX) && (C_op <= OP_COST);
   assign is_inv     = C_op > OP_COST;

   always_comb begin
      state_d      = state_q;
      key_d        = key_q;
      rcnt_d       = rcnt_q;
      x_d          = x_q;
      y_d          = y_q;
      z_d          = z_q;
      mask_d       = mask_q;
      cost_d       = cost_q;
      timer_d      = timer_q;
      err_d        = err_q;
      ready_d      = ready_q;
      over_d       = over_q;
      active_d     = active_q;
      lcnt_d       = lcnt_q;
      op_prev_d    = C_op;
      start_prev_d = C_start;
      // bad-key lockout: ready comes back as the counter expires
      if (lcnt_q != '0) begin
         lcnt_d  = lcnt_q - 1'b1;
         ready_d = (lcnt_q == LW'(1));
      end
      case (state_q)
         ST_UNLOCKED: begin
            if (start_edge) err_d = E_SUNL;
            else if (cmd_go) begin
               err_d = is_inv ? E_INV : (C_op == OP_UNLOCK) ? E_UNL : E_OK;
               if (C_op == OP_LOCK) begin
                  key_d   = C_data;
                  state_d = ST_LOCKED;
               end
               if (C_op == OP_LOADX) x_d = C_data;
               if (C_op == OP_LOADY) y_d = C_data;
               if (C_op == OP_LOADZ) z_d = C_data;
               if (C_op == OP_MASK)  mask_d = C_data[2:0];
               if (C_op == OP_TIMER) timer_d = C_data;
               if (C_op == OP_COST)  cost_d = C_data;
            end
         end
         ST_LOCKED: begin
            if (start_edge) begin
               if (timer_q == '0) err_d = E_STMR;
               else begin
                  err_d    = E_OK;
                  rcnt_d   = timer_q;
                  state_d  = ST_ACTIVE;
                  active_d = 1'b1;
                  ready_d  = 1'b0;
                  lcnt_d   = '0;
               end
            end else if (cmd_go) begin
               err_d = is_inv ? E_INV : is_cfg ? E_CFG : (C_op == OP_LOCK) ? E_LCK :
                       (C_data == key_q) ? E_OK : E_KEY;
               if (C_op == OP_UNLOCK && C_data == key_q) state_d = ST_UNLOCKED;
               if (C_op == OP_UNLOCK && C_data != key_q) begin
                  ready_d = (BAD_KEY_DELAY == 0);
                  lcnt_d  = LW'(BAD_KEY_DELAY);
               end
            end
         end
         ST_ACTIVE: begin
            if (rcnt_q == DATA_W'(1)) begin
               state_d  = ST_OVER;
               active_d = 1'b0;
               over_d   = 1'b1;
            end else rcnt_d = rcnt_q - 1'b1;
         end
         default: begin
            if (!C_start) begin
               state_d = ST_LOCKED;
               over_d  = 1'b0;
               ready_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_UNLOCKED;
         key_q        <= '0;
         rcnt_q       <= '0;
         x_q          <= '0;
         y_q          <= '0;
         z_q          <= '0;
         mask_q       <= 3'b111;
         cost_q       <= DATA_W'(1);
         timer_q      <= DATA_W'(DEFAULT_TIMER);
         err_q        <= E_OK;
         ready_q      <= 1'b1;
         over_q       <= 1'b0;
         active_q     <= 1'b0;
         lcnt_q       <= '0;
         op_prev_q    <= OP_NOP;
         start_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_q        <= key_d;
         rcnt_q       <= rcnt_d;
         x_q          <= x_d;
         y_q          <= y_d;
         z_q          <= z_d;
         mask_q       <= mask_d;
         cost_q       <= cost_d;
         timer_q      <= timer_d;
         err_q        <= err_d;
         ready_q      <= ready_d;
         over_q       <= over_d;
         active_q     <= active_d;
         lcnt_q       <= lcnt_d;
         op_prev_q    <= op_prev_d;
         start_prev_q <= start_prev_d;
      end
   end

   assign ready        = ready_q;
   assign err          = err_q;
   assign roundOver    = over_q;
   assign round_active = active_q;
   assign cfg_x_bal    = x_q;
   assign cfg_y_bal    = y_q;
   assign cfg_z_bal    = z_q;
   assign cfg_mask     = mask_q;
   assign cfg_cost     = cost_q;
   assign cfg_timer    = timer_q;
endmodule

// File: tb/tb_bids22_ctrl_resp.sv
// tb_bids22_ctrl_resp: directed self-checking bench for bids22_ctrl_resp.
module tb_bids22_ctrl_resp;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] C_data;
   logic [3:0]  C_op;
   logic        C_start;
   logic        ready, roundOver, round_active;
   logic [2:0]  err, cfg_mask;
   logic [31:0] cfg_x_bal, cfg_y_bal, cfg_z_bal, cfg_cost, cfg_timer;
   int          checks = 0;
   int          errors = 0;
   int          n;

   bids22_ctrl_resp dut (
      .clk(clk), .reset_n(reset_n), .C_data(C_data), .C_op(C_op), .C_start(C_start),
      .ready(ready), .err(err), .roundOver(roundOver), .round_active(round_active),
      .cfg_x_bal(cfg_x_bal), .cfg_y_bal(cfg_y_bal), .cfg_z_bal(cfg_z_bal),
      .cfg_mask(cfg_mask), .cfg_cost(cfg_cost), .cfg_timer(cfg_timer)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [3:0] op, input logic [31:0] data);
      C_op = op;
      C_data = data;
      tick();
      C_op = 4'd0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      C_data = '0;
      C_op = 4'd0;
      C_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ready, 1);
      check("rst_err", err, 0);
      check("rst_over", roundOver, 0);
      check("rst_active", round_active, 0);
      check("rst_mask", cfg_mask, 3'b111);
      check("rst_cost", cfg_cost, 1);
      check("rst_timer", cfg_timer, 16);
      check("rst_x", cfg_x_bal, 0);
      reset_n = 1'b1;
      tick();

      cmd(4'd3, 100);
      check("loadx", cfg_x_bal, 100);
      check("loadx_err", err, 0);
      cmd(4'd7, 5);
      check("settimer", cfg_timer, 5);
      cmd(4'd2, 32'hDEAD);
      check("lock_err", err, 0);

      C_op = 4'd1;
      C_data = 32'hBEEF;
      tick();
      check("badkey_err", err, 3'b001);
      C_op = 4'd0;
      n = 0;
      while (ready == 1'b0 && n < 30) begin
         n++;
         tick();
      end
      check("badkey_lockout", n, 8);
      cmd(4'd1, 32'hDEAD);
      check("unlock_ok", err, 0);
      cmd(4'd1, 0);
      check("unlock_unlocked", err, 3'b010);
      cmd(4'd2, 32'hDEAD);
      check("relock", err, 0);

      cmd(4'd4, 50);
      check("cfg_locked_err", err, 3'b100);
      check("cfg_locked_y", cfg_y_bal, 0);
      cmd(4'd2, 0);
      check("lock_locked", err, 3'b011);
      cmd(4'd12, 0);
      check("invalid_op", err, 3'b101);

      C_start = 1'b1;
      tick();
      check("start_err", err, 0);
      check("start_ready", ready, 0);
      n = 0;
      while (round_active == 1'b1 && n < 50) begin
         n++;
         tick();
      end
      check("round_len", n, 5);
      check("round_over", roundOver, 1);
      repeat (3) tick();
      check("over_hold", roundOver, 1);
      check("over_ready", ready, 0);
      C_start = 1'b0;
      tick();
      check("over_clear", roundOver, 0);
      check("over_ready1", ready, 1);

      cmd(4'd1, 32'hDEAD);
      check("unlock2", err, 0);
      C_op = 4'd5;
      for (int i = 0; i < 10; i++) begin
         C_data = 1000 + i;
         tick();
      end
      check("held_loadz", cfg_z_bal, 1000);
      C_op = 4'd0;
      tick();
      C_op = 4'd5;
      C_data = 7;
      tick();
      check("reissue_loadz", cfg_z_bal, 7);
      C_op = 4'd0;
      C_start = 1'b1;
      tick();
      check("start_unlocked", err, 3'b110);
      C_start = 1'b0;
      tick();

      cmd(4'd7, 0);
      cmd(4'd2, 32'h1234);
      C_start = 1'b1;
      C_op = 4'd2;
      tick();
      check("start_timer0", err, 3'b111);
      check("start_timer0_act", round_active, 0);
      C_start = 1'b0;
      C_op = 4'd0;
      tick();

      cmd(4'd1, 32'h1234);
      check("unlock3", err, 0);
      cmd(4'd7, 10);
      cmd(4'd2, 32'h55);
      C_start = 1'b1;
      tick();
      check("round2_active", round_active, 1);
      repeat (7) tick();
      check("round2_mid", round_active, 1);
      reset_n = 1'b0;
      #1;
      check("midrst_active", round_active, 0);
      check("midrst_ready", ready, 1);
      check("midrst_timer", cfg_timer, 16);
      check("midrst_x", cfg_x_bal, 0);
      C_start = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      cmd(4'd1, 0);
      check("postrst_unlocked", err, 3'b010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
